// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for the single-datapath RISC core. Each instruction
//   runs FETCH -> DECODE -> EXEC -> [MUL_WAIT | MEM] -> WB. The FSM raises
//   per-phase enable strobes. Illegal encodings and multiplier hangs go to a
//   sticky HALT state, which only reset can leave.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   opcode, fn_code          instruction fields taken from the IR
//   imem_ack, dmem_ack       instruction / data memory handshakes
//   mul_done                 multiplier result valid
//   branch_taken             condition evaluation, sampled in EXEC
//   imem_req, ir_write       fetch request and IR load strobe
//   mul_start                one-cycle multiplier kick
//   dmem_read, dmem_write    data memory request, held until dmem_ack
//   reg_write_en, pc_write   writeback strobes
//   pc_src                   0 = PC+1, 1 = branch/call/return target
//   illegal_instr            sticky flag for an illegal encoding
//   mul_timeout              sticky flag for a multiplier timeout
//   state                    current FSM state (debug)
//   instr_count              retired-instruction counter (wraps)

module multicycle_sequencer #(
  parameter int MUL_TIMEOUT = 16,   // 2..255
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic [3:0]       fn_code,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             mul_done,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_write,
  output logic             mul_start,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             reg_write_en,
  output logic             pc_write,
  output logic             pc_src,
  output logic             illegal_instr,
  output logic             mul_timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MUL_WAIT = 3'd3,
    S_MEM      = 3'd4,
    S_WB       = 3'd5,
    S_HALT     = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_ALU   = 4'd0,
    C_MUL   = 4'd1,
    C_LOAD  = 4'd2,
    C_STORE = 4'd3,
    C_JMP   = 4'd4,
    C_BCOND = 4'd5,
    C_CALL  = 4'd6,
    C_RET   = 4'd7,
    C_ILL   = 4'd8
  } cls_e;

  localparam logic [7:0] WAIT_LAST = 8'(MUL_TIMEOUT - 1);

  state_e     cur, nxt;
  cls_e       cls_d, cls_q;
  logic [7:0] wcnt;
  logic       mul_expire;

  assign state = cur;

  // The expiry cycle is the one where the counter shows MUL_TIMEOUT-1. That
  // gives exactly MUL_TIMEOUT MUL_WAIT cycles before the trap.
  assign mul_expire = (cur == S_MUL_WAIT) && (wcnt == WAIT_LAST);

  // Instruction class decode. The IR is stable from DECODE onward, so the
  // class is captured once in DECODE. Later phases then do not depend on the
  // IR contents.
  always_comb begin
    cls_d = C_ILL;
    case (opcode)
      4'd0: begin
        if (fn_code == 4'd1 || fn_code == 4'd2)
          cls_d = C_MUL;
        else if (fn_code == 4'd0 || (fn_code >= 4'd3 && fn_code <= 4'd5))
          cls_d = C_ALU;
      end
      4'd1:    if (fn_code <= 4'd1) cls_d = C_ALU;
      4'd2,
      4'd3:    if (fn_code <= 4'd2) cls_d = C_ALU;
      4'd4:    cls_d = C_LOAD;
      4'd5:    cls_d = C_STORE;
      4'd6:    if (fn_code <= 4'd1) cls_d = C_JMP;
      4'd7:    if (fn_code <= 4'd7) cls_d = C_BCOND;
      4'd8: begin
        if (fn_code == 4'd0)      cls_d = C_CALL;
        else if (fn_code == 4'd1) cls_d = C_RET;
      end
      default: cls_d = C_ILL;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= S_FETCH;
    else      cur <= nxt;
  end

  // Next state and strobes
  always_comb begin
    nxt          = cur;
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    mul_start    = 1'b0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    reg_write_en = 1'b0;
    pc_write     = 1'b0;
    case (cur)
      S_FETCH: begin
        // State sits at FETCH while reset is low. Gate the request so the
        // memory sees nothing until reset is released.
        imem_req = rst;
        ir_write = rst & imem_ack;
        if (imem_ack) nxt = S_DECODE;
      end
      S_DECODE: nxt = (cls_d == C_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        mul_start = (cls_q == C_MUL);
        case (cls_q)
          C_MUL:           nxt = S_MUL_WAIT;
          C_LOAD, C_STORE: nxt = S_MEM;
          default:         nxt = S_WB;
        endcase
      end
      S_MUL_WAIT: begin
        // A result arriving in the expiry cycle still counts as a result.
        if (mul_done)        nxt = S_WB;
        else if (mul_expire) nxt = S_HALT;
      end
      S_MEM: begin
        dmem_read  = (cls_q == C_LOAD);
        dmem_write = (cls_q == C_STORE);
        if (dmem_ack) nxt = S_WB;
      end
      S_WB: begin
        pc_write     = 1'b1;
        reg_write_en = (cls_q == C_ALU) || (cls_q == C_MUL) ||
                       (cls_q == C_LOAD) || (cls_q == C_CALL);
        nxt          = S_FETCH;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_HALT;  // the unused encoding 6 traps
    endcase
  end

  // Per-instruction context, sticky flags and the retire counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cls_q         <= C_ALU;
      wcnt          <= '0;
      pc_src        <= 1'b0;
      illegal_instr <= 1'b0;
      mul_timeout   <= 1'b0;
      instr_count   <= '0;
    end else begin
      case (cur)
        S_DECODE: begin
          cls_q <= cls_d;
          if (cls_d == C_ILL) illegal_instr <= 1'b1;
        end
        S_EXEC: begin
          wcnt <= '0;
          case (cls_q)
            C_JMP, C_CALL, C_RET: pc_src <= 1'b1;
            C_BCOND:              pc_src <= branch_taken;
            default:              pc_src <= 1'b0;
          endcase
        end
        S_MUL_WAIT: begin
          wcnt <= wcnt + 8'd1;
          if (mul_expire && !mul_done) mul_timeout <= 1'b1;
        end
        S_WB: instr_count <= instr_count + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer.
// Each instruction pushes its expected outcome into a scoreboard. The entry
// is popped when the DUT reaches WB or HALT, and the observed behaviour is
// compared against it.
module tb_multicycle_sequencer;
  localparam int CW = 8;  // narrow counter so the wrap test stays short

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    opcode, fn_code;
  logic          imem_ack, dmem_ack, mul_done, branch_taken;
  logic          imem_req, ir_write, mul_start, dmem_read, dmem_write;
  logic          reg_write_en, pc_write, pc_src, illegal_instr, mul_timeout;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;
  logic [6:0]    strobes;

  int vectors = 0, miscompares = 0;
  int exp_cnt = 0;

  typedef struct {
    logic rwe; logic psrc; logic halt;
    int lat; int nrd; int nwr; int nmul; int nmw;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign strobes = {imem_req, ir_write, mul_start, dmem_read, dmem_write,
                    reg_write_en, pc_write};

  multicycle_sequencer #(.MUL_TIMEOUT(16), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .fn_code(fn_code),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .mul_done(mul_done),
    .branch_taken(branch_taken), .imem_req(imem_req), .ir_write(ir_write),
    .mul_start(mul_start), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .reg_write_en(reg_write_en), .pc_write(pc_write), .pc_src(pc_src),
    .illegal_instr(illegal_instr), .mul_timeout(mul_timeout),
    .state(state), .instr_count(instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b0; mul_done = 1'b0;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_strobes", 32'(strobes), 0);
    chk("rst_flags", {30'd0, illegal_instr, mul_timeout}, 0);
    chk("rst_count", 32'(instr_count), 0);
    chk("rst_pcsrc", 32'(pc_src), 0);
    @(negedge clk);
    imem_ack = 1'b0;  // keep FETCH parked for one edge
    rst = 1'b1;
    #1;
    chk("rel_imem_req", 32'(imem_req), 1);
    chk("rel_state", 32'(state), 0);
    exp_cnt = 0;
  endtask

  // Plays memory/multiplier for one instruction, starting in FETCH.
  // mem_dly: dmem_ack in that MEM cycle. mul_dly: mul_done in that
  // MUL_WAIT cycle (0 = never).
  task automatic run_instr(input logic [3:0] op, input logic [3:0] fn,
                           input logic br, input int mem_dly, input int mul_dly,
                           input logic e_rwe, input logic e_psrc, input logic e_halt,
                           input int e_lat, input int e_nrd, input int e_nwr,
                           input int e_nmul, input int e_nmw,
                           output logic [31:0] trace);
    exp_t e, g;
    int cyc = 0, nrd = 0, nwr = 0, nmul = 0, nmw = 0, nir = 0;
    int nrwe = 0, npcw = 0, viol = 0, mc = 0;
    bit done = 0;
    logic [2:0] s = 3'd0;
    e = '{rwe:e_rwe, psrc:e_psrc, halt:e_halt, lat:e_lat, nrd:e_nrd,
          nwr:e_nwr, nmul:e_nmul, nmw:e_nmw};
    sb.push_back(e);
    trace = '0;
    opcode = op; fn_code = fn; branch_taken = br;
    while (!done && cyc < 64) begin
      @(negedge clk);
      s = state;
      trace = {trace[28:0], s};
      imem_ack = 1'b1;  // tied high: acks outside FETCH must be ignored
      dmem_ack = (s == 3'd4) && (mc + 1 == mem_dly);
      mul_done = (s == 3'd3) && (mul_dly != 0) && (nmw + 1 == mul_dly);
      #1;
      cyc++;
      nrd  += dmem_read    ? 1 : 0;
      nwr  += dmem_write   ? 1 : 0;
      nmul += mul_start    ? 1 : 0;
      nir  += ir_write     ? 1 : 0;
      nrwe += reg_write_en ? 1 : 0;
      npcw += pc_write     ? 1 : 0;
      if ((imem_req ? 1 : 0) + (dmem_read ? 1 : 0) + (dmem_write ? 1 : 0) > 1) viol++;
      if (s == 3'd4) mc++;
      if (s == 3'd3) nmw++;
      if (s == 3'd5 || s == 3'd7) begin
        done = 1;
        g = sb.pop_front();
        if (s == 3'd5) begin
          chk("wb_rwe", 32'(reg_write_en), 32'(g.rwe));
          chk("wb_pc_src", 32'(pc_src), 32'(g.psrc));
          chk("wb_pc_write", 32'(pc_write), 1);
        end
      end
    end
    if (!done) begin
      chk("timeout", 1, 0);
      g = sb.pop_front();
    end
    chk("halted", 32'(s == 3'd7), 32'(g.halt));
    if (!g.halt) chk("latency", cyc, g.lat);
    chk("n_dmem_read", nrd, g.nrd);
    chk("n_dmem_write", nwr, g.nwr);
    chk("n_mul_start", nmul, g.nmul);
    chk("n_mul_wait", nmw, g.nmw);
    chk("n_ir_write", nir, 1);
    chk("n_reg_write", nrwe, g.rwe ? 1 : 0);
    chk("n_pc_write", npcw, g.halt ? 0 : 1);
    chk("excl_req", viol, 0);
    if (done && !g.halt) begin
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      @(posedge clk); #1;
      chk("instr_count", 32'(instr_count), 32'(exp_cnt));
    end
  endtask

  logic [31:0] tr;
  logic [7:0]  ill [4];

  initial begin
    rst = 1'b0; opcode = '0; fn_code = '0; imem_ack = 1'b1;
    dmem_ack = 1'b0; mul_done = 1'b0; branch_taken = 1'b0;
    ill = '{8'h90, 8'h78, 8'h12, 8'h06};
    @(negedge clk);
    pulse_rst();

    // ALU: F,D,E,WB
    run_instr(4'd0, 4'd0, 1'b0, 1, 0, 1, 0, 0, 4, 0, 0, 0, 0, tr);
    chk("alu_trace", tr, 32'o0125);
    // LOAD / STORE with ack in the third MEM cycle, then a fast load
    run_instr(4'd4, 4'd0, 1'b0, 3, 0, 1, 0, 0, 7, 3, 0, 0, 0, tr);
    chk("load_trace", tr, 32'o0124445);
    run_instr(4'd5, 4'd3, 1'b0, 3, 0, 0, 0, 0, 7, 0, 3, 0, 0, tr);
    run_instr(4'd4, 4'd9, 1'b0, 1, 0, 1, 0, 0, 5, 1, 0, 0, 0, tr);
    // branches and control transfers
    run_instr(4'd7, 4'd0, 1'b1, 1, 0, 0, 1, 0, 4, 0, 0, 0, 0, tr);
    run_instr(4'd7, 4'd0, 1'b0, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0, tr);
    run_instr(4'd7, 4'd7, 1'b1, 1, 0, 0, 1, 0, 4, 0, 0, 0, 0, tr);
    run_instr(4'd6, 4'd1, 1'b0, 1, 0, 0, 1, 0, 4, 0, 0, 0, 0, tr);
    run_instr(4'd8, 4'd0, 1'b0, 1, 0, 1, 1, 0, 4, 0, 0, 0, 0, tr);
    run_instr(4'd8, 4'd1, 1'b0, 1, 0, 0, 1, 0, 4, 0, 0, 0, 0, tr);
    // more ALU encodings (pc_src must fall back to 0)
    run_instr(4'd3, 4'd2, 1'b1, 1, 0, 1, 0, 0, 4, 0, 0, 0, 0, tr);
    run_instr(4'd0, 4'd5, 1'b0, 1, 0, 1, 0, 0, 4, 0, 0, 0, 0, tr);
    // MUL with the result in the fifth wait cycle
    run_instr(4'd0, 4'd1, 1'b0, 1, 5, 1, 0, 0, 9, 0, 0, 1, 5, tr);
    // MUL with the result in the expiry cycle: the result wins
    run_instr(4'd0, 4'd2, 1'b0, 1, 16, 1, 0, 0, 20, 0, 0, 1, 16, tr);
    chk("no_timeout_flag", 32'(mul_timeout), 0);
    // MUL that never completes: 16 wait cycles, then HALT
    run_instr(4'd0, 4'd2, 1'b0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 16, tr);
    chk("mul_timeout", 32'(mul_timeout), 1);
    chk("mt_illegal", 32'(illegal_instr), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imem_ack = 1'b1; dmem_ack = 1'b1; mul_done = 1'b1;
      #1;
      chk("halt_strobes", 32'(strobes), 0);
      chk("halt_state", 32'(state), 7);
      chk("halt_sticky", 32'(mul_timeout), 1);
    end
    chk("halt_count", 32'(instr_count), 32'(exp_cnt));
    pulse_rst();

    // illegal encodings trap from DECODE
    for (int i = 0; i < 4; i++) begin
      logic [7:0] enc;
      enc = ill[i];
      run_instr(enc[7:4], enc[3:0], 1'b0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, tr);
      chk("ill_trace", tr, 32'o017);
      chk("illegal_flag", 32'(illegal_instr), 1);
      chk("ill_no_mt", 32'(mul_timeout), 0);
      pulse_rst();
    end

    // reset during MEM aborts the load
    run_instr(4'd1, 4'd1, 1'b0, 1, 0, 1, 0, 0, 4, 0, 0, 0, 0, tr);
    opcode = 4'd4; fn_code = 4'd0; imem_ack = 1'b1; dmem_ack = 1'b0;
    for (int i = 0; i < 10 && state != 3'd4; i++) @(negedge clk);
    chk("mem_reached", 32'(state), 4);
    #1;
    chk("mem_read_hi", 32'(dmem_read), 1);
    rst = 1'b0;
    #1;
    chk("abort_read", 32'(dmem_read), 0);
    chk("abort_strobes", 32'(strobes), 0);
    chk("abort_state", 32'(state), 0);
    @(negedge clk);
    imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_rel_req", 32'(imem_req), 1);
    chk("abort_count", 32'(instr_count), 0);
    exp_cnt = 0;

    // counter wrap: 2^CW retirements return the count to 0
    for (int i = 0; i < (1 << CW); i++)
      run_instr(4'd2, 4'(i % 3), 1'b0, 1, 0, 1, 0, 0, 4, 0, 0, 0, 0, tr);
    chk("count_wrap", 32'(instr_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that sequences the single-datapath RISC core: fetch, decode, execute, optional multiply wait or memory access, then writeback.
- Consumes the same 4-bit opcode/fn_code fields as the instruction decoder.
- Generates per-phase enable strobes: IR load, memory request, multiplier start, register-file write and PC update.
- Traps illegal encodings and multiplier hangs into a sticky HALT state.

Parameters:
- MUL_TIMEOUT, 16: max MUL_WAIT cycles before a timeout trap (range 2..255).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- opcode  in  4  instruction opcode field (IR output)
- fn_code  in  4  instruction function field (IR output)
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- mul_done  in  1  multiplier result valid
- branch_taken  in  1  condition-flag evaluation result, valid in EXEC
- imem_req  out  1  instruction fetch request
- ir_write  out  1  IR load strobe
- mul_start  out  1  multiplier start pulse
- dmem_read  out  1  data memory read request
- dmem_write  out  1  data memory write request
- reg_write_en  out  1  register-file write strobe
- pc_write  out  1  PC update strobe
- pc_src  out  1  0 = PC+1, 1 = branch/call/return target
- illegal_instr  out  1  sticky illegal-encoding flag
- mul_timeout  out  1  sticky multiplier-timeout flag
- state  out  3  current state, for debug
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- One clock. Reset is asynchronous and active-low (rst=0 resets).
- While rst=0:
  - state=FETCH; counters, pc_src and sticky flags = 0.
  - Every output is 0, including imem_req, which is gated by rst.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MUL_WAIT=3, MEM=4, WB=5, HALT=7.
- Instruction classes:
  - ALU: op0 fn0,3,4,5; op1 fn0-1; op2 fn0-2; op3 fn0-2.
  - MUL: op0 fn1-2.
  - LOAD: op4.
  - STORE: op5.
  - JMP: op6 fn0-1.
  - BCOND: op7 fn0-7.
  - CALL: op8 fn0.
  - RET: op8 fn1.
  - Any other encoding is illegal.
- FETCH:
  - imem_req=1.
  - ir_write = imem_ack, combinational, same cycle.
  - imem_ack -> DECODE; otherwise stay in FETCH.
- DECODE: lasts 1 cycle. Illegal encoding -> HALT and set illegal_instr; otherwise -> EXEC.
- EXEC: lasts 1 cycle.
  - mul_start=1 for MUL only.
  - pc_src register loaded: JMP/CALL/RET -> 1; BCOND -> branch_taken; otherwise 0.
  - Next state: MUL -> MUL_WAIT (wait counter cleared); LOAD/STORE -> MEM; others -> WB.
- MUL_WAIT:
  - Wait counter increments every cycle.
  - mul_done -> WB.
  - Counter reaches MUL_TIMEOUT-1 without mul_done -> HALT and set mul_timeout.
  - If mul_done and the timeout occur in the same cycle, mul_done wins.
- MEM:
  - dmem_read (LOAD) or dmem_write (STORE) held high continuously until dmem_ack.
  - Exits to WB in the cycle after dmem_ack. No timeout.
- WB: lasts 1 cycle.
  - pc_write=1.
  - reg_write_en=1 for ALU, MUL, LOAD, CALL only.
  - instr_count increments, wrapping from all-ones to 0.
  - -> FETCH.
- HALT:
  - All strobes 0; no exit except reset.
  - Sticky flags hold until reset.
- Latency with single-cycle acks (FETCH through WB):
  - ALU/branch: 4 cycles.
  - LOAD/STORE: 5 cycles.
  - MUL: 4 cycles plus MUL_WAIT cycles.
- Strobe rules:
  - At most one of imem_req/dmem_read/dmem_write is high in any cycle.
  - mul_start, ir_write, reg_write_en and pc_write are never high for more than 1 cycle per instruction.
- Acks arriving outside their requesting state are ignored.
- Reset asserted mid-instruction:
  - Immediate abort: no reg_write_en or pc_write for the aborted instruction.
  - First cycle after release: FETCH with imem_req=1.

Test Plan:
- ALU op0/fn0, imem_ack and dmem_ack tied 1 -> states 0,1,2,5,0; reg_write_en=1 and pc_write=1 in cycle 4; pc_src=0; instr_count=1.
- LOAD op4, dmem_ack delayed 3 cycles -> dmem_read high 3 cycles, MEM exits the cycle after ack; WB reg_write_en=1; STORE op5 repeat -> dmem_write high, reg_write_en=0 in WB.
- BCOND op7/fn0: branch_taken=1 in EXEC -> pc_src=1 in WB; repeat with branch_taken=0 -> pc_src=0; both cases reg_write_en=0.
- MUL op0/fn1: mul_done after 5 cycles -> mul_start single pulse, WB reached; then mul_done never asserted with MUL_TIMEOUT=16 -> HALT after 16 MUL_WAIT cycles, mul_timeout=1, all strobes 0 thereafter.
- Illegal op9 -> HALT from DECODE, illegal_instr=1, no pc_write; rst pulsed low -> flag cleared, FETCH with imem_req=1.
- rst driven low during MEM with dmem_read high -> dmem_read drops immediately, no WB strobes; 65536 ALU instructions retired -> instr_count wraps to 0.
